// File: rtl/cdc_tx_ctrl.sv
// Sender-side req/ack controller: buffers an upstream stream in a small FIFO and
// sends one word at a time over a 4-phase handshake. Define CDC_TX_TIMEOUT_EN for the phase timeout.
module cdc_tx_ctrl #(
    parameter int W       = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_l,
    input  logic                     rst_l,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    output logic                     req_l,
    input  logic                     ack_l,
    output logic [W-1:0]             data_l,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           push;
    logic           pop;
    logic           req_next;
    logic           timeout_hit;
    logic [W-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("cdc_tx_ctrl: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (count != '0);

    always_ff @(posedge clk_l) begin
        if (rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new handshake may only start once the receiver has dropped any previous ack.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if ((count != '0) && !ack_l) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack_l) begin
                    state_next = REL;
                end else if (timeout_hit) begin
                    state_next = IDLE;
                end
            end
            REL: begin
                if (!ack_l || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == IDLE) && (state_next == REQ);
        req_next = (state_next == REQ);
    end

    always_ff @(posedge clk_l) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_l) begin
        if (rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // data_l only loads on the pop edge so it stays frozen for the whole crossing.
    always_ff @(posedge clk_l) begin
        if (rst_l) begin
            req_l  <= 1'b0;
            data_l <= '0;
        end else begin
            req_l <= req_next;
            if (pop) begin
                data_l <= mem[rd_ptr];
            end
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;

    // Exits the phase on the edge where the counter would reach TIMEOUT.
    assign timeout_hit = (state != IDLE) && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_l) begin
        if (rst_l) begin
            timer <= '0;
            err   <= 1'b0;
        end else begin
            if (state_next != state) begin
                timer <= '0;
            end else if (state != IDLE) begin
                timer <= timer + TW'(1);
            end
            if (timeout_hit) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_tx_ctrl.sv
// Directed testbench for cdc_tx_ctrl: reset, single word, burst to full,
// simultaneous push/pop, stale ack, reset mid-handshake, optional timeout.
module tb_cdc_tx_ctrl;

    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic          clk_l = 1'b0;
    logic          rst_l;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          req_l;
    logic          ack_l;
    logic [W-1:0]  data_l;
    logic          busy;
    logic [2:0]    count;
    logic          err;

    logic          auto_ack;
    logic          ack_manual;
    logic          req_d1 = 1'b0;
    logic          req_d2 = 1'b0;

    int            checks = 0;
    int            errors = 0;

    logic [W-1:0]  rx_words [$];
    logic [W-1:0]  exp_words [$];
    logic          req_prev = 1'b0;
    logic          hold_valid = 1'b0;
    logic [W-1:0]  held = '0;

    cdc_tx_ctrl #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (8)
    ) dut (
        .clk_l    (clk_l),
        .rst_l    (rst_l),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .req_l    (req_l),
        .ack_l    (ack_l),
        .data_l   (data_l),
        .busy     (busy),
        .count    (count),
        .err      (err)
    );

    always #5 clk_l = ~clk_l;

    // Receiver model: ack follows req through a 2-cycle delay when enabled.
    always @(posedge clk_l) begin
        req_d1 <= req_l;
        req_d2 <= req_d1;
    end
    assign ack_l = auto_ack ? req_d2 : ack_manual;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Captures every word at its req rise and checks it stays put until the handshake ends.
    always @(negedge clk_l) begin
        if (rst_l) begin
            hold_valid = 1'b0;
            req_prev   = 1'b0;
        end else begin
            if (req_l && !req_prev) begin
                rx_words.push_back(data_l);
                held       = data_l;
                hold_valid = 1'b1;
            end else if (hold_valid) begin
                checkOutput("data_hold", {16'h0, data_l}, {16'h0, held});
                if (!busy) hold_valid = 1'b0;
            end
            req_prev = req_l;
        end
    end

    task automatic applyStimulus(input logic [W-1:0] word);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk_l);
            n++;
        end
        checkOutput("push_ready", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        in_data  = word;
        exp_words.push_back(word);
        @(negedge clk_l);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk_l);
            n++;
        end
        checkOutput("drain_done", {31'h0, busy}, 32'h0);
        @(negedge clk_l);
    endtask

    task automatic check_rx();
        checkOutput("rx_count", rx_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < rx_words.size(); i++) begin
            checkOutput($sformatf("rx_word%0d", i), {16'h0, rx_words[i]}, {16'h0, exp_words[i]});
        end
        rx_words.delete();
        exp_words.delete();
    endtask

    task automatic pulse_reset();
        rst_l = 1'b1;
        @(negedge clk_l);
        checkOutput("rst_req", {31'h0, req_l}, 32'h0);
        checkOutput("rst_count", {29'h0, count}, 32'h0);
        checkOutput("rst_ready", {31'h0, in_ready}, 32'h1);
        checkOutput("rst_data", {16'h0, data_l}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy}, 32'h0);
        checkOutput("rst_err", {31'h0, err}, 32'h0);
        @(negedge clk_l);
        rst_l = 1'b0;
        rx_words.delete();
        exp_words.delete();
    endtask

    initial begin
        rst_l      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        auto_ack   = 1'b0;
        ack_manual = 1'b0;
        repeat (2) @(negedge clk_l);
        pulse_reset();

        $display("[TB] single word");
        auto_ack = 1'b1;
        applyStimulus(16'hA5A5);
        checkOutput("single_req_early", {31'h0, req_l}, 32'h0);
        checkOutput("single_count", {29'h0, count}, 32'h1);
        checkOutput("single_busy", {31'h0, busy}, 32'h1);
        @(negedge clk_l);
        checkOutput("single_req", {31'h0, req_l}, 32'h1);
        checkOutput("single_data", {16'h0, data_l}, 32'hA5A5);
        checkOutput("single_count_pop", {29'h0, count}, 32'h0);
        wait_drain();
        checkOutput("single_req_done", {31'h0, req_l}, 32'h0);
        check_rx();

        $display("[TB] burst to full");
        auto_ack = 1'b0;
        ack_manual = 1'b0;
        for (int i = 1; i <= 5; i++) applyStimulus(W'(i));
        checkOutput("full_count", {29'h0, count}, 32'h4);
        checkOutput("full_ready", {31'h0, in_ready}, 32'h0);
        checkOutput("full_req", {31'h0, req_l}, 32'h1);
        checkOutput("full_data", {16'h0, data_l}, 32'h1);
        auto_ack = 1'b1;
        applyStimulus(16'h0006);
        wait_drain();
        check_rx();

        $display("[TB] simultaneous push and pop");
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        checkOutput("pp_count", {29'h0, count}, 32'h1);
        checkOutput("pp_req", {31'h0, req_l}, 32'h1);
        checkOutput("pp_data", {16'h0, data_l}, 32'h1111);
        wait_drain();
        check_rx();

        $display("[TB] stale ack");
        auto_ack   = 1'b0;
        ack_manual = 1'b1;
        applyStimulus(16'h3333);
        applyStimulus(16'h4444);
        checkOutput("stale_count", {29'h0, count}, 32'h2);
        checkOutput("stale_req", {31'h0, req_l}, 32'h0);
        repeat (2) @(negedge clk_l);
        checkOutput("stale_count_hold", {29'h0, count}, 32'h2);
        checkOutput("stale_req_hold", {31'h0, req_l}, 32'h0);
        ack_manual = 1'b0;
        @(negedge clk_l);
        checkOutput("stale_release_req", {31'h0, req_l}, 32'h1);
        checkOutput("stale_release_data", {16'h0, data_l}, 32'h3333);
        checkOutput("stale_release_count", {29'h0, count}, 32'h1);
        auto_ack = 1'b1;
        wait_drain();
        check_rx();

        $display("[TB] reset mid-REQ");
        auto_ack   = 1'b0;
        ack_manual = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(W'(16'h00C0 + i));
        checkOutput("midrst_req_before", {31'h0, req_l}, 32'h1);
        checkOutput("midrst_count_before", {29'h0, count}, 32'h3);
        pulse_reset();

`ifdef CDC_TX_TIMEOUT_EN
        $display("[TB] handshake timeout");
        applyStimulus(16'h7777);
        applyStimulus(16'h8888);
        repeat (7) @(negedge clk_l);
        checkOutput("to_req_wait", {31'h0, req_l}, 32'h1);
        checkOutput("to_err_wait", {31'h0, err}, 32'h0);
        @(negedge clk_l);
        checkOutput("to_err", {31'h0, err}, 32'h1);
        checkOutput("to_req_drop", {31'h0, req_l}, 32'h0);
        checkOutput("to_count", {29'h0, count}, 32'h1);
        @(negedge clk_l);
        checkOutput("to_next_req", {31'h0, req_l}, 32'h1);
        checkOutput("to_next_data", {16'h0, data_l}, 32'h8888);
        checkOutput("to_err_sticky", {31'h0, err}, 32'h1);
        pulse_reset();
`endif

        $display("[TB] single word after reset");
        auto_ack = 1'b1;
        applyStimulus(16'h5A5A);
        wait_drain();
        check_rx();
        checkOutput("final_err", {31'h0, err}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
